gppm_acumulador: RTL and testbench
==================================

Name: gppm_acumulador

Overview:
- Parametrised successor to the two-operand adder front-end of the GPPM datapath.
- Loads NUM_OPS operands of DATA_W bits into GPPM registers 0..NUM_OPS-1 by immediate writes.
- Folds them through one selectable ALU op into accumulator register ACC_REG = NUM_OPS, then holds the result until restart.
- Drives the GPPM 64-bit instruction word and reads back gppm_out and is_zero. The GPPM is instantiated alongside, not inside.

Parameters:
- DATA_W, 3, operand/result width; 1..32 (immediate field is instruction[21+DATA_W:22]).
- NUM_OPS, 2, operands per operation; 2..30.
- OP_W, 4, ALU opcode width (instruction[19:16]); fixed at 4.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- num  in  DATA_W  operand value, live.
- enter  in  1  operand strobe; only a rising edge (0->1 between consecutive clk samples) counts.
- op_sel  in  4  ALU opcode; latched on the enter edge that accepts the last operand.
- restart  in  1  level; returns DONE -> LOAD.
- gppm_out  in  32  GPPM ALU/result bus.
- is_zero  in  1  GPPM zero flag.
- instruction  out  64  GPPM instruction word.
- res  out  DATA_W  registered result.
- res_zero  out  1  registered is_zero of final step.
- done  out  1  high in DONE.
- busy  out  1  high in COMPUTE.
- idx  out  5  operand index being loaded (LOAD) or compute step (COMPUTE).

Behaviour:
- Instruction fields: [5:1] srcA reg; [10:6] srcB reg; [15:11] dest reg; [19:16] op; [20] 1 = ALU / 0 = immediate; [21] write enable; [21+DATA_W:22] immediate. All other bits 0.
- instruction is combinational from state, idx, latched op and live num.
- Reset (reset==0 at posedge), from any state including mid-COMPUTE:
  - state=LOAD, idx=0, op latch=0, enter-edge register=0.
  - res=0, res_zero=0, done=0, busy=0.
- LOAD:
  - instruction: dest=idx, [20]=0, [21]=1, imm=num, all else 0.
  - On an enter edge with idx<NUM_OPS-1: idx++.
  - On an enter edge with idx==NUM_OPS-1: latch op_sel, idx<=1, go COMPUTE.
  - Held or level-high enter never advances more than once per edge.
- COMPUTE (busy=1), one instruction per cycle, steps k=1..NUM_OPS-1 (idx=k):
  - srcA = 0 when k==1, else ACC_REG.
  - srcB = k; dest = ACC_REG; op = latched op; [20]=1; [21]=1.
  - When k<NUM_OPS-1: idx++.
  - When k==NUM_OPS-1: res<=gppm_out[DATA_W-1:0], res_zero<=is_zero, go DONE, idx<=0.
  - Latency: last enter edge to done = NUM_OPS-1 cycles. NUM_OPS=2 gives exactly one COMPUTE cycle.
  - enter, op_sel and restart are ignored in COMPUTE.
- DONE (done=1):
  - instruction = all zeros (no write). res and res_zero held.
  - restart==1 -> LOAD, idx=0; res is kept until the next final step.
  - enter is ignored, but the edge detector keeps tracking, so an enter held high across restart does not count in LOAD.
- Arithmetic: result is whatever the GPPM produces, truncated to the low DATA_W bits; wrap is modulo 2^DATA_W with no saturation or overflow flag.
- Simultaneous events:
  - reset==0 beats everything.
  - restart and an enter edge in the same DONE cycle: go LOAD, enter not counted.

Test Plan:
- DATA_W=4, NUM_OPS=3, op_sel=0000 (add), GPPM model attached; enter edges with num=5,7,6 -> instruction shows imm writes to regs 0,1,2; two COMPUTE cycles (srcA=0,srcB=1,dest=3, then srcA=3,srcB=2,dest=3); done on 2nd cycle after last edge; res=2 (18 mod 16), res_zero=0.
- DATA_W=3, NUM_OPS=2, num=3 then 5, add -> one COMPUTE cycle; res=0, res_zero=1; instruction in COMPUTE = srcA 0, srcB 1, dest 2, bits 20 and 21 set.
- enter held high 10 cycles in LOAD -> idx advances by exactly 1; a second edge is needed to advance again.
- reset driven 0 during COMPUTE step 1 of NUM_OPS=4 -> next cycle state LOAD, idx=0, busy=0, res=0, instruction = immediate write to reg 0.
- In DONE, pulse enter without restart -> no change. Assert restart while enter is held high -> LOAD with idx=0; the first operand is only accepted after enter drops and rises again; res keeps its old value until the new computation completes.
- op_sel changed during LOAD and COMPUTE -> only the value present at the last enter edge appears in instruction[19:16] for all COMPUTE cycles.

Source files
------------

// File: rtl/gppm_acumulador_if.sv
// Bundle of the accumulator's operator-facing and GPPM-facing signals.
// The accumulator drives the GPPM instruction word and its status outputs.
// The environment (operator inputs plus the GPPM itself) drives the rest.
interface gppm_acumulador_if #(
  parameter int DATA_W = 3
);
  logic [DATA_W-1:0] num;
  logic              enter;
  logic [3:0]        op_sel;
  logic              restart;
  logic [31:0]       gppm_out;
  logic              is_zero;
  logic [63:0]       instruction;
  logic [DATA_W-1:0] res;
  logic              res_zero;
  logic              done;
  logic              busy;
  logic [4:0]        idx;

  // Accumulator side.
  modport master (
    input  num, enter, op_sel, restart, gppm_out, is_zero,
    output instruction, res, res_zero, done, busy, idx
  );

  // Environment side: operator stimulus and the GPPM datapath.
  modport slave (
    output num, enter, op_sel, restart, gppm_out, is_zero,
    input  instruction, res, res_zero, done, busy, idx
  );
endinterface

// File: rtl/gppm_acumulador.sv
// GPPM accumulator front-end.
// Loads NUM_OPS operands into GPPM registers 0..NUM_OPS-1 by immediate
// writes, folds them through one ALU op into register NUM_OPS, then holds
// the truncated result until restart.
module gppm_acumulador #(
  parameter int DATA_W  = 3,
  parameter int NUM_OPS = 2,
  parameter int OP_W    = 4
) (
  input logic               clk,
  input logic               reset,
  gppm_acumulador_if.master bus
);

  localparam logic [4:0] ACC_REG  = 5'(NUM_OPS);
  localparam logic [4:0] LAST_IDX = 5'(NUM_OPS - 1);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [4:0]        idx_reg, idx_next;
  logic [OP_W-1:0]   op_reg, op_next;
  logic              enter_reg;
  logic [DATA_W-1:0] res_reg, res_next;
  logic              res_zero_reg, res_zero_next;
  logic              enter_edge;
  logic [63:0]       instr;

  // The edge detector samples enter in every state, so a level held across
  // restart is not mistaken for a fresh strobe once back in LOAD.
  assign enter_edge = bus.enter & ~enter_reg;

  // State, index, op latch, edge detector and result registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= LOAD;
      idx_reg      <= '0;
      op_reg       <= '0;
      enter_reg    <= 1'b0;
      res_reg      <= '0;
      res_zero_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      op_reg       <= op_next;
      enter_reg    <= bus.enter;
      res_reg      <= res_next;
      res_zero_reg <= res_zero_next;
    end
  end

  // Next-state logic: operand counting, compute stepping, result capture.
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    op_next       = op_reg;
    res_next      = res_reg;
    res_zero_next = res_zero_reg;
    case (state_reg)
      LOAD: begin
        if (enter_edge) begin
          if (idx_reg == LAST_IDX) begin
            op_next    = bus.op_sel;
            idx_next   = 5'd1;
            state_next = COMPUTE;
          end else begin
            idx_next = idx_reg + 5'd1;
          end
        end
      end
      COMPUTE: begin
        if (idx_reg == LAST_IDX) begin
          // The GPPM result bus carries the final fold this cycle.
          res_next      = bus.gppm_out[DATA_W-1:0];
          res_zero_next = bus.is_zero;
          idx_next      = '0;
          state_next    = DONE;
        end else begin
          idx_next = idx_reg + 5'd1;
        end
      end
      DONE: begin
        // restart wins over a coincident enter edge; the edge is dropped.
        if (bus.restart) begin
          idx_next   = '0;
          state_next = LOAD;
        end
      end
      default: begin
        idx_next   = '0;
        state_next = LOAD;
      end
    endcase
  end

  // Instruction word: immediate writes in LOAD, ALU folds in COMPUTE, idle in DONE.
  always_comb begin
    instr = '0;
    case (state_reg)
      LOAD: begin
        instr[15:11]          = idx_reg;
        instr[21]             = 1'b1;
        instr[21+DATA_W:22]   = bus.num;
      end
      COMPUTE: begin
        // First step combines operands 0 and 1; later steps fold into ACC.
        instr[5:1]   = (idx_reg == 5'd1) ? 5'd0 : ACC_REG;
        instr[10:6]  = idx_reg;
        instr[15:11] = ACC_REG;
        instr[19:16] = op_reg;
        instr[20]    = 1'b1;
        instr[21]    = 1'b1;
      end
      default: instr = '0;
    endcase
  end

  assign bus.instruction = instr;
  assign bus.res         = res_reg;
  assign bus.res_zero    = res_zero_reg;
  assign bus.done        = (state_reg == DONE);
  assign bus.busy        = (state_reg == COMPUTE);
  assign bus.idx         = idx_reg;

endmodule

// File: tb/tb_gppm_acumulador.sv
// Directed bench for gppm_acumulador: three instances (4b/3 ops, 3b/2 ops,
// 4b/4 ops), each with a small behavioural GPPM register file and ALU.
module tb_gppm_acumulador;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  gppm_acumulador_if #(.DATA_W(4)) ia ();
  gppm_acumulador_if #(.DATA_W(3)) ib ();
  gppm_acumulador_if #(.DATA_W(4)) ic ();

  gppm_acumulador #(.DATA_W(4), .NUM_OPS(3), .OP_W(4)) dut_a (.clk(clk), .reset(reset), .bus(ia));
  gppm_acumulador #(.DATA_W(3), .NUM_OPS(2), .OP_W(4)) dut_b (.clk(clk), .reset(reset), .bus(ib));
  gppm_acumulador #(.DATA_W(4), .NUM_OPS(4), .OP_W(4)) dut_c (.clk(clk), .reset(reset), .bus(ic));

  // GPPM ALU: 0 add, 1 sub, 2 and, 3 or; result wraps to the datapath width.
  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input int w);
    logic [31:0] r;
    logic [31:0] mask;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      default: r = '0;
    endcase
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return r & mask;
  endfunction

  logic [31:0] rf_a [32];
  logic [31:0] rf_b [32];
  logic [31:0] rf_c [32];

  assign ia.gppm_out = alu(ia.instruction[19:16], rf_a[ia.instruction[5:1]], rf_a[ia.instruction[10:6]], 4);
  assign ia.is_zero  = (ia.gppm_out == 32'd0);
  assign ib.gppm_out = alu(ib.instruction[19:16], rf_b[ib.instruction[5:1]], rf_b[ib.instruction[10:6]], 3);
  assign ib.is_zero  = (ib.gppm_out == 32'd0);
  assign ic.gppm_out = alu(ic.instruction[19:16], rf_c[ic.instruction[5:1]], rf_c[ic.instruction[10:6]], 4);
  assign ic.is_zero  = (ic.gppm_out == 32'd0);

  // GPPM register file writes, one per instance.
  always_ff @(posedge clk) begin
    if (ia.instruction[21])
      rf_a[ia.instruction[15:11]] <= ia.instruction[20] ? ia.gppm_out : {28'd0, ia.instruction[25:22]};
    if (ib.instruction[21])
      rf_b[ib.instruction[15:11]] <= ib.instruction[20] ? ib.gppm_out : {29'd0, ib.instruction[24:22]};
    if (ic.instruction[21])
      rf_c[ic.instruction[15:11]] <= ic.instruction[20] ? ic.gppm_out : {28'd0, ic.instruction[25:22]};
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_a(input logic [3:0] v);
    ia.num = v; ia.enter = 1'b1; tick(); ia.enter = 1'b0; tick();
    $display("load a num=%0d idx=%0d", v, ia.idx);
  endtask

  task automatic load_c(input logic [3:0] v);
    ic.num = v; ic.enter = 1'b1; tick(); ic.enter = 1'b0; tick();
    $display("load c num=%0d idx=%0d", v, ic.idx);
  endtask

  localparam logic [63:0] WE  = 64'd1 << 21;
  localparam logic [63:0] ALU = (64'd1 << 20) | (64'd1 << 21);

  initial begin
    ia.num = '0; ia.enter = 0; ia.op_sel = 4'd0; ia.restart = 0;
    ib.num = '0; ib.enter = 0; ib.op_sel = 4'd0; ib.restart = 0;
    ic.num = '0; ic.enter = 0; ic.op_sel = 4'd0; ic.restart = 0;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();

    // Reset state.
    check_val("rst_done", 64'(ia.done), 64'd0);
    check_val("rst_busy", 64'(ia.busy), 64'd0);
    check_val("rst_idx", 64'(ia.idx), 64'd0);
    check_val("rst_res", 64'(ia.res), 64'd0);
    check_val("rst_res_zero", 64'(ia.res_zero), 64'd0);
    ia.num = 4'd5; #1;
    check_val("a_load0_instr", ia.instruction, WE | (64'd5 << 22));

    // Scenario A: 5 + 7 + 6 = 18 -> 2 in 4 bits.
    load_a(4'd5);
    check_val("a_idx1", 64'(ia.idx), 64'd1);
    load_a(4'd7);
    check_val("a_idx2", 64'(ia.idx), 64'd2);
    ia.num = 4'd6; #1;
    check_val("a_load2_instr", ia.instruction, WE | (64'd6 << 22) | (64'd2 << 11));
    ia.enter = 1'b1; tick();
    $display("a compute step idx=%0d instr=%h", ia.idx, ia.instruction);
    check_val("a_step1_busy", 64'(ia.busy), 64'd1);
    check_val("a_step1_instr", ia.instruction, ALU | (64'd1 << 6) | (64'd3 << 11));
    ia.enter = 1'b0; tick();
    $display("a compute step idx=%0d instr=%h", ia.idx, ia.instruction);
    check_val("a_step2_idx", 64'(ia.idx), 64'd2);
    check_val("a_step2_instr", ia.instruction, ALU | (64'd3 << 1) | (64'd2 << 6) | (64'd3 << 11));
    check_val("a_step2_done", 64'(ia.done), 64'd0);
    tick();
    $display("a done res=%0d res_zero=%0d", ia.res, ia.res_zero);
    check_val("a_done", 64'(ia.done), 64'd1);
    check_val("a_res", 64'(ia.res), 64'd2);
    check_val("a_res_zero", 64'(ia.res_zero), 64'd0);
    check_val("a_done_instr", ia.instruction, 64'd0);
    check_val("a_done_busy", 64'(ia.busy), 64'd0);

    // Enter pulse in DONE is ignored.
    ia.enter = 1'b1; tick(); ia.enter = 1'b0; tick();
    check_val("a_done_enter_done", 64'(ia.done), 64'd1);
    check_val("a_done_enter_idx", 64'(ia.idx), 64'd0);

    // Restart while enter is held high: no operand counted in LOAD.
    ia.enter = 1'b1; tick();
    ia.restart = 1'b1; tick();
    ia.restart = 1'b0;
    $display("a restart done=%0d idx=%0d", ia.done, ia.idx);
    check_val("a_restart_done", 64'(ia.done), 64'd0);
    check_val("a_restart_idx", 64'(ia.idx), 64'd0);
    tick(); tick();
    check_val("a_held_idx", 64'(ia.idx), 64'd0);
    check_val("a_res_kept", 64'(ia.res), 64'd2);
    ia.enter = 1'b0; tick();

    // Enter held high for 10 cycles advances exactly once.
    ia.op_sel = 4'd2;
    ia.num = 4'd1; ia.enter = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check_val("a_hold_idx", 64'(ia.idx), 64'd1);
    ia.enter = 1'b0; ia.num = 4'd3; tick();
    check_val("a_hold_release_idx", 64'(ia.idx), 64'd1);
    ia.op_sel = 4'd1;
    load_a(4'd3);
    check_val("a_second_edge_idx", 64'(ia.idx), 64'd2);

    // Op latched at the last edge (OR); later op_sel changes are ignored.
    ia.op_sel = 4'd3; ia.num = 4'd4; ia.enter = 1'b1; tick();
    ia.op_sel = 4'd1; ia.enter = 1'b0;
    check_val("a_or_step1_op", 64'(ia.instruction[19:16]), 64'd3);
    check_val("a_res_kept_compute", 64'(ia.res), 64'd2);
    tick();
    ia.op_sel = 4'd0;
    check_val("a_or_step2_op", 64'(ia.instruction[19:16]), 64'd3);
    tick();
    $display("a done res=%0d res_zero=%0d", ia.res, ia.res_zero);
    check_val("a_or_res", 64'(ia.res), 64'd7);
    check_val("a_or_done", 64'(ia.done), 64'd1);

    // Scenario B: 3 + 5 = 8 -> 0 in 3 bits, single compute cycle.
    ib.num = 3'd3; ib.enter = 1'b1; tick(); ib.enter = 1'b0; tick();
    ib.num = 3'd5; ib.enter = 1'b1; tick();
    ib.enter = 1'b0;
    $display("b compute step idx=%0d instr=%h", ib.idx, ib.instruction);
    check_val("b_busy", 64'(ib.busy), 64'd1);
    check_val("b_instr", ib.instruction, ALU | (64'd1 << 6) | (64'd2 << 11));
    tick();
    $display("b done res=%0d res_zero=%0d", ib.res, ib.res_zero);
    check_val("b_done", 64'(ib.done), 64'd1);
    check_val("b_res", 64'(ib.res), 64'd0);
    check_val("b_res_zero", 64'(ib.res_zero), 64'd1);

    // Scenario C: 1+2+3+4 = 10, three compute cycles.
    load_c(4'd1); load_c(4'd2); load_c(4'd3);
    ic.num = 4'd4; ic.enter = 1'b1; tick(); ic.enter = 1'b0;
    tick();
    check_val("c_step2_done", 64'(ic.done), 64'd0);
    tick();
    check_val("c_step3_idx", 64'(ic.idx), 64'd3);
    tick();
    $display("c done res=%0d res_zero=%0d", ic.res, ic.res_zero);
    check_val("c_done", 64'(ic.done), 64'd1);
    check_val("c_res", 64'(ic.res), 64'd10);

    // Restart, reload, then reset during compute step 1.
    ic.restart = 1'b1; tick(); ic.restart = 1'b0;
    load_c(4'd2); load_c(4'd2); load_c(4'd2);
    ic.num = 4'd2; ic.enter = 1'b1; tick(); ic.enter = 1'b0;
    check_val("c_mid_busy", 64'(ic.busy), 64'd1);
    check_val("c_mid_idx", 64'(ic.idx), 64'd1);
    reset = 1'b0; tick(); reset = 1'b1;
    ic.num = 4'd9; #1;
    $display("c reset busy=%0d idx=%0d res=%0d", ic.busy, ic.idx, ic.res);
    check_val("c_rst_busy", 64'(ic.busy), 64'd0);
    check_val("c_rst_idx", 64'(ic.idx), 64'd0);
    check_val("c_rst_res", 64'(ic.res), 64'd0);
    check_val("c_rst_done", 64'(ic.done), 64'd0);
    check_val("c_rst_instr", ic.instruction, WE | (64'd9 << 22));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
